// File: rtl/pio_sensor_in_if.sv
// rtl/pio_sensor_in_if.sv - Avalon-MM register bus bundle for pio_sensor_in
interface pio_sensor_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_sensor_in.sv
// rtl/pio_sensor_in.sv - synchronised, debounced sensor PIO with edge capture and irq
module pio_sensor_in #(
  parameter int WIDTH           = 9,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_sensor_in_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // A debounce depth of 0 behaves exactly like 1: a single register stage.
  localparam int N  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;

  logic [WIDTH-1:0]          d_q, d_d;
  logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]          ev;

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;

  // Only the low WIDTH bits of writedata are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  // Per-bit debounce: accept a new level only after N consecutive differing samples.
  always_comb begin
    d_d   = d_q;
    cnt_d = cnt_q;
    ev    = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (s[b] == d_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        d_d[b]   = s[b];
        cnt_d[b] = '0;
        case (EDGE_TYPE)
          0:       ev[b] = s[b];
          1:       ev[b] = ~s[b];
          default: ev[b] = 1'b1;
        endcase
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_ONE;
      end
    end
  end

  // Register file next-state, read mux and interrupt source.
  always_comb begin
    wr_en  = bus.chipselect & ~bus.write_n;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && (bus.address == 2'd2)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && (bus.address == 2'd3)) begin
      clr = bus.writedata[WIDTH-1:0];
    end
    // A set in the same cycle as a clear wins so no event is ever lost.
    edge_d = (edge_q & ~clr) | ev;

    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d = 32'(d_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(edge_q);
      default: readdata_d = '0;
    endcase

    if (IRQ_MODE == 0) begin
      irq_d = |(d_q & mask_q);
    end else begin
      irq_d = |(edge_q & mask_q);
    end
  end

  // State registers; reset discards any partially counted debounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q        <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pio_sensor_in.sv
// tb/tb_pio_sensor_in.sv - directed self-checking bench for pio_sensor_in
module tb_pio_sensor_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic [4:0]  cs;
  logic        write_n;
  logic [31:0] writedata;
  logic [8:0]  in0, in1, in2, in3, in4;
  logic        irq0, irq1, irq2, irq3, irq4;

  int chk_cnt;
  int pass_cnt;
  int fail_cnt;

  pio_sensor_in_if b0 ();
  pio_sensor_in_if b1 ();
  pio_sensor_in_if b2 ();
  pio_sensor_in_if b3 ();
  pio_sensor_in_if b4 ();

  assign b0.address = address; assign b0.chipselect = cs[0];
  assign b0.write_n = write_n; assign b0.writedata  = writedata;
  assign b1.address = address; assign b1.chipselect = cs[1];
  assign b1.write_n = write_n; assign b1.writedata  = writedata;
  assign b2.address = address; assign b2.chipselect = cs[2];
  assign b2.write_n = write_n; assign b2.writedata  = writedata;
  assign b3.address = address; assign b3.chipselect = cs[3];
  assign b3.write_n = write_n; assign b3.writedata  = writedata;
  assign b4.address = address; assign b4.chipselect = cs[4];
  assign b4.write_n = write_n; assign b4.writedata  = writedata;

  pio_sensor_in #(.WIDTH(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_MODE(1))
    u0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave), .in_port(in0), .irq(irq0));
  pio_sensor_in #(.WIDTH(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_MODE(1))
    u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave), .in_port(in1), .irq(irq1));
  pio_sensor_in #(.WIDTH(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_MODE(1))
    u2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave), .in_port(in2), .irq(irq2));
  pio_sensor_in #(.WIDTH(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1), .IRQ_MODE(1))
    u3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave), .in_port(in3), .irq(irq3));
  pio_sensor_in #(.WIDTH(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_MODE(0))
    u4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave), .in_port(in4), .irq(irq4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [1:0] a, input logic [31:0] wd);
    cs        = 5'(1 << idx);
    address   = a;
    write_n   = 1'b0;
    writedata = wd;
    tick(1);
    cs        = '0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
    reset_n = 1'b0; address = 2'd0; cs = '0; write_n = 1'b1; writedata = '0;
    in0 = 9'h1FF; in1 = '0; in2 = '0; in3 = '0; in4 = '0;

    // Reset held with inputs high
    tick(3);
    chk("reset_rd0", b0.readdata, 32'h0);
    chk("reset_irq0", {31'b0, irq0}, 32'h0);
    chk("reset_rd1", b1.readdata, 32'h0);

    // Release: DATA visible 4 clocks later
    reset_n = 1'b1;
    tick(3);
    chk("rel_rd0_c3", b0.readdata, 32'h0);
    tick(1);
    chk("rel_rd0_c4", b0.readdata, 32'h1FF);

    // Debounce N=4: 3-cycle glitch rejected
    in1[3] = 1'b1;
    tick(3);
    in1[3] = 1'b0;
    tick(8);
    chk("glitch_data", b1.readdata, 32'h0);
    address = 2'd3;
    tick(1);
    chk("glitch_edge", b1.readdata, 32'h0);
    chk("glitch_irq", {31'b0, irq1}, 32'h0);

    // Debounce N=4: step accepted 6 clocks later, edge + irq follow
    wr(1, 2'd2, 32'h008);
    address = 2'd0;
    in1[3]  = 1'b1;
    tick(6);
    chk("step_data_c6", b1.readdata, 32'h0);
    chk("step_irq_c6", {31'b0, irq1}, 32'h0);
    tick(1);
    chk("step_data_c7", b1.readdata, 32'h008);
    chk("step_irq_c7", {31'b0, irq1}, 32'h1);
    address = 2'd3;
    tick(1);
    chk("step_edge", b1.readdata, 32'h008);

    // W1C clear: irq drops one clock after the write
    wr(1, 2'd3, 32'h008);
    chk("w1c_irq_wr", {31'b0, irq1}, 32'h1);
    tick(1);
    chk("w1c_edge", b1.readdata, 32'h0);
    chk("w1c_irq", {31'b0, irq1}, 32'h0);

    // Set/clear collision: W1C lands on the edge where d rises
    in1[3] = 1'b0;
    tick(8);
    in1[3] = 1'b1;
    tick(5);
    wr(1, 2'd3, 32'h008);
    tick(1);
    chk("coll_edge", b1.readdata, 32'h008);
    chk("coll_irq", {31'b0, irq1}, 32'h1);
    tick(1);
    chk("coll_irq_hold", {31'b0, irq1}, 32'h1);

    // EDGE_TYPE=any with MASK=0, then unmask
    in2[0] = 1'b1;
    tick(4);
    in2[0] = 1'b0;
    tick(4);
    chk("any_edge", b2.readdata, 32'h001);
    chk("any_irq_masked", {31'b0, irq2}, 32'h0);
    wr(2, 2'd2, 32'h001);
    chk("any_irq_wr", {31'b0, irq2}, 32'h0);
    tick(1);
    chk("any_irq_unmask", {31'b0, irq2}, 32'h1);

    // EDGE_TYPE=falling: rise ignored, fall captured
    address = 2'd3;
    in3[0]  = 1'b1;
    tick(5);
    chk("fall_rise", b3.readdata, 32'h0);
    in3[0] = 1'b0;
    tick(5);
    chk("fall_fall", b3.readdata, 32'h001);

    // Level mode: irq follows d with 1 clock lag
    wr(4, 2'd2, 32'h100);
    in4[8] = 1'b1;
    tick(6);
    chk("lvl_rise_c6", {31'b0, irq4}, 32'h0);
    tick(1);
    chk("lvl_rise_c7", {31'b0, irq4}, 32'h1);
    in4[8] = 1'b0;
    tick(6);
    chk("lvl_fall_c6", {31'b0, irq4}, 32'h1);
    tick(1);
    chk("lvl_fall_c7", {31'b0, irq4}, 32'h0);

    // Asynchronous reset mid-debounce clears outputs without a clock edge
    address = 2'd3;
    in4[8]  = 1'b1;
    tick(3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_irq1", {31'b0, irq1}, 32'h0);
    chk("mid_rst_rd1", b1.readdata, 32'h0);
    chk("mid_rst_rd0", b0.readdata, 32'h0);
    tick(2);

    // After release a full SYNC_STAGES+N sequence is needed again
    address = 2'd0;
    reset_n = 1'b1;
    tick(6);
    chk("post_rd1_c6", b1.readdata, 32'h0);
    chk("post_rd4_c6", b4.readdata, 32'h0);
    tick(1);
    chk("post_rd1_c7", b1.readdata, 32'h008);
    chk("post_rd4_c7", b4.readdata, 32'h100);
    address = 2'd3;
    tick(1);
    chk("post_edge1", b1.readdata, 32'h008);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pio_sensor_in.md
# pio_sensor_in

Parametrised Avalon-MM read/write slave for sampling a bank of asynchronous sensor inputs. It provides input synchronisation, per-bit debounce, a configurable edge-capture register, an interrupt mask and an interrupt output. It sits on the Nios II system interconnect and is the successor to the fixed-width read-only sensor PIO. It supplies both polled line state and interrupt-driven event detection to software.

## Interface
- WIDTH, 9: number of input bits (1..32).
- SYNC_STAGES, 2: synchroniser flops per bit (2..4).
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required to accept a change. 0 behaves as 1, i.e. no filtering beyond one register.
- EDGE_TYPE, 0: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.
- IRQ_MODE, 1: interrupt source. 0 = level on (data & mask), 1 = edge on (capture & mask).

- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous sensor inputs.
- readdata  out  32  registered read data.
- irq  out  1  registered interrupt request, active high.

## Operation
- Register map:
  - 0 DATA (RO): debounced line state.
  - 1: reads 0, writes ignored.
  - 2 MASK (RW): WIDTH bits, reset 0.
  - 3 EDGE (R/W1C): capture bits, reset 0.
- Readdata carries the register in bits [WIDTH-1:0] and zeros above. Writes to addresses 0 and 1 have no effect.
- Synchroniser: SYNC_STAGES-deep flop chain per bit, reset 0. Its output is s.
- Debounce, per bit:
  - Holds a stable value d (reset 0) and a counter cnt (reset 0, width clog2(N+1), where N = max(DEBOUNCE_CYCLES,1)).
  - If s == d: cnt <= 0.
  - Else if cnt == N-1: d <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than N cycles never changes d.
- Edge event, per bit: asserted on the clock where d updates. Rising means the new d=1, falling means the new d=0, any means either.
- EDGE register:
  - A bit sets on an edge event.
  - A write to address 3 clears each bit whose writedata bit is 1.
  - If set and clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- MASK: a write loads writedata[WIDTH-1:0].
- irq: IRQ_MODE=0 gives irq <= |(d & MASK); IRQ_MODE=1 gives irq <= |(EDGE & MASK). Both are evaluated on current register values.
- Reset asserted at any time: every flop clears immediately, including synchroniser, d, cnt, MASK, EDGE, readdata and irq. Partially counted debounce is discarded.

## Timing
- Reset values: readdata = 0, irq = 0.
- Read latency is 1 cycle. readdata is updated every clock from the address presented in the previous cycle, independent of chipselect. There are no wait states.
- Write takes effect on the clock edge where it is sampled. A read of the same register in the next cycle returns the new value.
- in_port step to DATA change: SYNC_STAGES + N clocks to d. A read issued after that returns the new d one clock later.
- EDGE bit sets on the same edge as the d update.
- irq in edge mode: 1 clock after EDGE sets. In level mode: 1 clock after d updates.
- irq deasserts 1 clock after the clearing write or the mask write.
- Mask changes take effect on irq one clock after the write.

## Test plan
- Reset check (WIDTH=9, SYNC_STAGES=2, DEBOUNCE_CYCLES=0): hold reset_n=0 with in_port=9'h1FF -> readdata=0, irq=0. Release reset and read address 0 -> 0x1FF, first visible on readdata 4 clocks after release.
- Debounce filtering (DEBOUNCE_CYCLES=4):
  - Bit 3 pulse of 3 cycles -> DATA stays 0x000, EDGE stays 0.
  - Bit 3 pulse of 4+ cycles -> DATA = 0x008 exactly 2+4 clocks after the step.
- Edge capture rising (IRQ_MODE=1):
  - MASK=0x008, bit 3 rises -> EDGE=0x008, irq=1 one clock later.
  - Write 0x008 to address 3 -> EDGE=0, irq=0 next clock.
- Set/clear collision: schedule the W1C write to address 3 on the exact cycle a new rising edge on bit 3 is accepted -> EDGE bit 3 remains 1 and irq stays 1.
- Mask and edge types:
  - EDGE_TYPE=2 with MASK=0: toggle bit 0 -> EDGE=0x001 and irq stays 0. Then write MASK=0x001 -> irq=1 one clock later.
  - EDGE_TYPE=1: rising edge on bit 0 sets nothing.
- Level mode and mid-operation reset:
  - IRQ_MODE=0 with MASK=0x100: drive bit 8 high -> irq follows d with 1 clock lag.
  - Assert reset_n mid-debounce -> all outputs 0 immediately, and no event is captured after release until a full SYNC_STAGES+N sequence completes.
